// File: rtl/pipeline_scoreboard.sv
// pipeline_scoreboard: issue hazard scoreboard with shadow writeback pipeline and regfile write-port arbiter
module pipeline_scoreboard #(
  parameter int reg_width = 6,
  parameter int depth = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid_i,
  input  logic [reg_width-1:0] issue_src1_i,
  input  logic [reg_width-1:0] issue_src2_i,
  input  logic                 issue_src1_used_i,
  input  logic                 issue_src2_used_i,
  input  logic [reg_width-1:0] issue_dest_i,
  input  logic                 issue_wen_i,
  output logic                 issue_ready_o,
  input  logic                 stall_external_i,
  input  logic                 flush_i,
  input  logic                 net_reg_write_cmd_i,
  input  logic [reg_width-1:0] net_reg_addr_i,
  output logic                 net_grant_o,
  output logic                 wb_valid_o,
  output logic [reg_width-1:0] wb_dest_o,
  output logic [15:0]          stall_cycles_o
);
  logic [depth-1:0]     valid_q, valid_d, valid_c;
  logic [reg_width-1:0] dest_q [depth];
  logic [reg_width-1:0] dest_d [depth];
  logic [15:0]          stall_cycles_q, stall_cycles_d;
  logic                 s1_live, s2_live, hazard, accept;
  always_comb begin
    s1_live = issue_src1_used_i && issue_src1_i != '0;
    s2_live = issue_src2_used_i && issue_src2_i != '0;
    hazard = net_reg_write_cmd_i &&
             ((s1_live && net_reg_addr_i == issue_src1_i) || (s2_live && net_reg_addr_i == issue_src2_i));
    for (int n = 0; n < depth; n++)
      hazard = hazard || (valid_q[n] &&
               ((s1_live && dest_q[n] == issue_src1_i) || (s2_live && dest_q[n] == issue_src2_i)));
    issue_ready_o = !hazard && !stall_external_i;
    accept = issue_valid_i && issue_ready_o && !flush_i;
    wb_valid_o = valid_q[depth-1] && !stall_external_i;
    wb_dest_o = dest_q[depth-1];
    net_grant_o = net_reg_write_cmd_i && !wb_valid_o;
    stall_cycles_o = stall_cycles_q;
    stall_cycles_d = (issue_valid_i && !issue_ready_o && stall_cycles_q != 16'hFFFF) ?
                     stall_cycles_q + 16'd1 : stall_cycles_q;
    for (int n = 0; n < depth; n++)
      valid_c[n] = valid_q[n] && !(flush_i && n < depth - 1);
    valid_d = stall_external_i ? valid_c :
              {valid_c[depth-2:0], accept && issue_wen_i && issue_dest_i != '0};
    dest_d[0] = stall_external_i ? dest_q[0] : (accept ? issue_dest_i : '0);
    for (int n = 1; n < depth; n++)
      dest_d[n] = stall_external_i ? dest_q[n] : dest_q[n-1];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dest_q <= '{default: '0};
      stall_cycles_q <= '0;
    end else begin
      valid_q <= valid_d;
      dest_q <= dest_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end
endmodule

// File: tb/tb_pipeline_scoreboard.sv
// tb_pipeline_scoreboard: randomized scoreboard bench against an in-flight-write list model
module tb_pipeline_scoreboard;
  localparam int W = 6;
  localparam int D = 3;
  logic         clk = 1'b0;
  logic         reset, issue_valid_i, issue_src1_used_i, issue_src2_used_i, issue_wen_i;
  logic [W-1:0] issue_src1_i, issue_src2_i, issue_dest_i, net_reg_addr_i, wb_dest_o;
  logic         issue_ready_o, stall_external_i, flush_i, net_reg_write_cmd_i, net_grant_o, wb_valid_o;
  logic [15:0]  stall_cycles_o;
  always #5 clk = ~clk;
  pipeline_scoreboard #(.reg_width(W), .depth(D)) dut (
    .clk(clk), .reset(reset),
    .issue_valid_i(issue_valid_i), .issue_src1_i(issue_src1_i), .issue_src2_i(issue_src2_i),
    .issue_src1_used_i(issue_src1_used_i), .issue_src2_used_i(issue_src2_used_i),
    .issue_dest_i(issue_dest_i), .issue_wen_i(issue_wen_i), .issue_ready_o(issue_ready_o),
    .stall_external_i(stall_external_i), .flush_i(flush_i),
    .net_reg_write_cmd_i(net_reg_write_cmd_i), .net_reg_addr_i(net_reg_addr_i),
    .net_grant_o(net_grant_o), .wb_valid_o(wb_valid_o), .wb_dest_o(wb_dest_o),
    .stall_cycles_o(stall_cycles_o)
  );
  typedef struct {
    bit chk; bit wchk; bit rdy; bit wbv; int wbd; bit gnt; int sc;
  } exp_t;
  exp_t sb[$];
  int   vectors = 0, miscompares = 0;
  int   fl_dest[$], fl_pos[$];
  bit   known = 0, just_reset = 0, nc_v = 0;
  int   sc_m = 0, na_v = 0;
  task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] x);
    vectors++;
    if (a !== x) begin
      miscompares++;
      if (miscompares <= 30) $display("FAIL %s at %0t: got %0h expected %0h", n, $time, a, x);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.chk) begin
        cmp("issue_ready", {31'd0, issue_ready_o}, e.rdy);
        cmp("wb_valid", {31'd0, wb_valid_o}, e.wbv);
        cmp("net_grant", {31'd0, net_grant_o}, e.gnt);
        cmp("stall_cycles", {16'd0, stall_cycles_o}, e.sc);
        if (e.wchk) cmp("wb_dest", {26'd0, wb_dest_o}, e.wbd);
      end
    end
  end
  task automatic go(input bit r, input bit v, input int s1, input bit u1, input int s2, input bit u2,
                    input int d, input bit we, input bit stl, input bit fl);
    exp_t e;
    bit   haz;
    int   nd[$], np[$];
    reset = r; issue_valid_i = v; issue_src1_i = s1[W-1:0]; issue_src1_used_i = u1;
    issue_src2_i = s2[W-1:0]; issue_src2_used_i = u2; issue_dest_i = d[W-1:0]; issue_wen_i = we;
    stall_external_i = stl; flush_i = fl; net_reg_write_cmd_i = nc_v; net_reg_addr_i = na_v[W-1:0];
    haz = nc_v && ((u1 && s1 != 0 && na_v == s1) || (u2 && s2 != 0 && na_v == s2));
    foreach (fl_dest[i]) haz |= (u1 && s1 != 0 && fl_dest[i] == s1) || (u2 && s2 != 0 && fl_dest[i] == s2);
    e.chk = known; e.rdy = !haz && !stl; e.wbv = 0; e.wbd = 0; e.sc = sc_m;
    foreach (fl_pos[i]) if (fl_pos[i] == D - 1) begin e.wbv = !stl; e.wbd = fl_dest[i]; end
    e.wchk = e.wbv || just_reset;
    e.gnt = nc_v && !e.wbv;
    sb.push_back(e);
    just_reset = 0;
    if (r) begin
      fl_dest.delete(); fl_pos.delete(); sc_m = 0; known = 1; just_reset = 1;
    end else begin
      if (v && !e.rdy && sc_m < 65535) sc_m++;
      foreach (fl_pos[i]) begin
        if (fl && fl_pos[i] < D - 1) continue;
        if (!stl && fl_pos[i] == D - 1) continue;
        nd.push_back(fl_dest[i]); np.push_back(stl ? fl_pos[i] : fl_pos[i] + 1);
      end
      if (v && e.rdy && !fl && we && d != 0) begin nd.push_back(d); np.push_back(0); end
      fl_dest = nd; fl_pos = np;
    end
    if (e.gnt) nc_v = 0;
    @(posedge clk); #1;
  endtask
  task automatic idle(input int n);
    repeat (n) go(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    @(posedge clk); #1;
    go(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    go(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 5; i <= 7; i++) go(0, 1, 0, 0, 0, 0, i, 1, 0, 0);
    idle(4);
    go(0, 1, 0, 0, 0, 0, 5, 1, 0, 0);
    repeat (4) go(0, 1, 5, 1, 0, 0, 6, 1, 0, 0);
    go(0, 1, 0, 0, 0, 0, 5, 1, 0, 0);
    repeat (2) go(0, 1, 0, 1, 5, 0, 8, 1, 0, 0);
    idle(4);
    go(0, 1, 0, 0, 0, 0, 5, 1, 0, 0);
    idle(2);
    nc_v = 1; na_v = 9;
    repeat (3) go(0, 1, 9, 1, 0, 0, 0, 0, 0, 0);
    idle(2);
    for (int i = 1; i <= 3; i++) go(0, 1, 0, 0, 0, 0, i, 1, 0, 0);
    go(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    go(0, 1, 1, 1, 2, 1, 0, 0, 0, 0);
    idle(4);
    go(0, 1, 0, 0, 0, 0, 4, 1, 0, 0);
    idle(1);
    repeat (4) go(0, 1, 4, 1, 0, 0, 0, 0, 1, 0);
    repeat (4) go(0, 1, 4, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) go(0, 1, 0, 0, 0, 0, i, 1, 0, 0);
    go(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(4);
    for (int k = 0; k < 3000; k++) begin
      if (!nc_v && $urandom_range(0, 5) == 0) begin nc_v = 1; na_v = $urandom_range(0, 7); end
      go($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
         $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
         $urandom_range(0, 7), $urandom_range(0, 3) != 0,
         $urandom_range(0, 4) == 0, $urandom_range(0, 15) == 0);
    end
    nc_v = 0;
    idle(4);
    repeat (70000) go(0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    @(negedge clk); #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pipeline_scoreboard.md
# pipeline_scoreboard

Issue-side scoreboard and register-file write-port scheduler for the lab core pipeline. It decides each cycle whether the decode-stage instruction may issue. To do that it tracks every in-flight register write in a depth-stage shadow pipeline (EX/MEM/WB) and compares decode sources against those writes. It also shares the single register-file write port between pipeline writeback and network register-write commands. It sits between decode and EX, alongside the register file, and produces the core's stall signal.

## Interface
- reg_width, default 6: register address width.
- depth, default 3: number of tracked stages from issue to writeback. Stage 0 is EX, stage depth-1 is WB. Legal range 2..8.
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state on the next rising edge.
- issue_valid_i  in  1  decode holds a valid instruction.
- issue_src1_i, issue_src2_i  in  reg_width  decode source registers.
- issue_src1_used_i, issue_src2_used_i  in  1  the matching source is actually read.
- issue_dest_i  in  reg_width  decode destination register.
- issue_wen_i  in  1  the instruction writes issue_dest_i.
- issue_ready_o  out  1  no hazard; decode may advance this cycle.
- stall_external_i  in  1  memory/downstream freeze; the shadow pipeline holds.
- flush_i  in  1  branch squash.
- net_reg_write_cmd_i  in  1  network requests a register write; held until granted.
- net_reg_addr_i  in  reg_width  network target register.
- net_grant_o  out  1  the network write commits to the register file this cycle.
- wb_valid_o  out  1  the WB-stage entry writes the register file this cycle.
- wb_dest_o  out  reg_width  WB-stage destination.
- stall_cycles_o  out  16  saturating count of cycles with issue_valid_i=1 and issue_ready_o=0.

## Operation
- **State**
  - Shift register of depth entries, each holding {valid, dest}.
  - 16-bit stall counter.
- **Hazard**
  - A source hazards when its used bit is 1, the source is nonzero, and it equals the dest of any valid entry in any stage, WB included (there is no regfile write-through bypass).
  - A used source that equals net_reg_addr_i while net_reg_write_cmd_i=1 also hazards.
  - Register 0 never hazards.
  - issue_ready_o = !hazard && !stall_external_i, evaluated combinationally.
- **Accept**
  - An issue is accepted when issue_valid_i && issue_ready_o && !flush_i.
  - On acceptance, stage 0 loads {issue_wen_i && issue_dest_i!=0, issue_dest_i}.
  - Otherwise stage 0 loads a bubble (valid=0).
- **Advance**
  - When stall_external_i=0, each stage n copies stage n-1 and the WB entry retires.
  - When stall_external_i=1, all stages hold. Exception: a net grant may still occur while stalled.
- **Flush**
  - flush_i=1 clears valid in stages 0..depth-2.
  - The WB entry still commits.
  - The instruction in decode is not accepted.
  - flush_i overrides stall_external_i.
- **Write-port arbitration**
  - WB has priority.
  - net_grant_o = net_reg_write_cmd_i && !(wb_valid_o).
  - The network holds cmd and addr stable until it sees the grant.
- **Outputs**
  - wb_valid_o = valid of stage depth-1 && !stall_external_i.
  - wb_dest_o = dest of stage depth-1.
- **Counter**
  - Increments when issue_valid_i && !issue_ready_o.
  - Saturates at 16'hFFFF.

## Timing
- **Reset values:** all entries invalid; issue_ready_o=1 (with stall_external_i=0); net_grant_o=0; wb_valid_o=0; wb_dest_o=0; stall_cycles_o=0.
- **Reset mid-operation:** all in-flight entries are discarded on the reset edge, and no writeback is issued for them.
- **Producer latency:** a producer accepted at edge t is in stage 0 after t.
  - It reaches WB after edge t+depth-1, when wb_valid_o is high for that cycle.
  - A dependent instruction becomes ready in the cycle after that WB cycle.
  - With depth=3: a producer accepted at cycle 0 gives a dependent accepted at cycle 4, after 3 stall cycles.
- **Back-to-back independent instructions:** issue every cycle with no bubbles.
- **Simultaneous net command and WB write:** the net command waits one cycle; the grant comes in the first cycle without a WB write.
- **Simultaneous flush and WB:** WB commits and the younger stages clear on the same edge.
- **Same register as source and dest:** handled by the hazard check against older entries only. The issuing instruction never hazards on itself.
- **net_grant_o:** combinational from the current cmd and the WB stage; no registered latency.

## Test plan
- **Reset then independent issue:** reset for 2 cycles, then issue dest r5, r6, r7 on consecutive cycles -> issue_ready_o=1 throughout; wb_valid_o pulses with wb_dest_o=5,6,7 in cycles 3,4,5.
- **RAW stall:** issue a write to r5 at cycle 0, then a reader of src1=r5 from cycle 1 -> issue_ready_o=0 in cycles 1–3, 1 in cycle 4; stall_cycles_o=3. Repeat with src=r0 -> no stall.
- **Network arbitration:** hold net cmd to r9 while WB writes r5 -> net_grant_o=0 that cycle and 1 the next. A reader of r9 stalls until the grant cycle passes.
- **Flush:** with r1, r2, r3 in EX/MEM/WB, assert flush_i -> only r3 commits; readers of r1 and r2 are ready the next cycle.
- **External stall:** hold stall_external_i for 4 cycles with r4 in MEM -> entries frozen, wb_valid_o=0, issue_ready_o=0; the pipeline resumes with r4 reaching WB one cycle after release.
- **Mid-operation reset and counter saturation:** assert reset with three entries in flight -> no WB pulses afterwards. Force 70000 stall cycles -> stall_cycles_o=16'hFFFF.
